// File: rtl/mux_display_ndigit_pkg.sv
// Shared constants and helpers for the N-digit multiplexed 7-segment driver.
// Glyphs are stored active-high in {a,b,c,d,e,f,g} bit order (a = bit 6).
package mux_display_ndigit_pkg;

  localparam int unsigned PHASES = 16;

  localparam logic [6:0] BLANK_SEG = 7'h00;

  localparam logic [6:0] GLYPH [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return GLYPH[nib];
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit act_low);
    return act_low ? ~seg : seg;
  endfunction

  // Sub-tick divider: one slot of PHASES sub-ticks per scan period, never below 1.
  function automatic int unsigned sub_div(input int unsigned clk_hz, input int unsigned scan_hz);
    int unsigned d;
    d = clk_hz / (scan_hz * PHASES);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/mux_display_ndigit_tick.sv
// Free-running prescaler: one-cycle o_tick every DIV cycles, synchronous active-high R.
module tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic ck,
  input  logic R,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge ck) begin
    if (R)                  r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/mux_display_ndigit.sv
// N-digit multiplexed 7-segment driver with double-buffered load, per-digit
// decimal points, 16-level PWM brightness and leading-zero suppression.
module mux_display_ndigit
  import mux_display_ndigit_pkg::*;
#(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic               ck,
  input  logic               R,
  input  logic               load,
  input  logic [4*N_DIG-1:0] data,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [3:0]         bright,
  input  logic               lz_en,
  output logic [N_DIG-1:0]   Dig,
  output logic [6:0]         L,
  output logic               H,
  output logic               frame
);

  localparam int unsigned    SUB_DIV  = sub_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned    IW       = $clog2(N_DIG);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_DIG - 1);
  localparam logic [6:0]     SEG_OFF  = seg_pol(BLANK_SEG, SEG_ACT_LOW);
  localparam logic           DP_OFF   = SEG_ACT_LOW;

  logic                w_tick;
  logic                w_slot_end;
  logic                w_wrap;
  logic [3:0]          r_phase;
  logic [IW-1:0]       r_idx;
  logic [3:0]          r_bright;
  logic [4*N_DIG-1:0]  r_pend_data;
  logic [N_DIG-1:0]    r_pend_dp;
  logic                r_pend;
  logic [4*N_DIG-1:0]  r_disp_data;
  logic [N_DIG-1:0]    r_disp_dp;
  logic                r_frame;
  logic [N_DIG-1:0]    r_dig;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [N_DIG-1:0]    w_supp;
  logic [3:0]          w_nib;
  logic                w_drive;
  logic [N_DIG-1:0]    w_dig_nxt;
  logic [6:0]          w_seg_nxt;
  logic                w_dp_nxt;

  tick_gen #(.DIV(SUB_DIV)) u_tick (
    .ck     (ck),
    .R      (R),
    .o_tick (w_tick)
  );

  assign w_slot_end = w_tick && (r_phase == 4'(PHASES - 1));
  assign w_wrap     = w_slot_end && (r_idx == LAST_IDX);

  // Suppression runs from the top digit down and stops at the first nonzero
  // nibble or lit point; digit 0 is never suppressed.
  always_comb begin
    w_supp = '0;
    w_supp[N_DIG-1] = (r_disp_data[4*(N_DIG-1) +: 4] == 4'h0) && !r_disp_dp[N_DIG-1];
    for (int unsigned i = 1; i < N_DIG - 1; i++) begin
      w_supp[N_DIG-1-i] = w_supp[N_DIG-i]
                        && (r_disp_data[4*(N_DIG-1-i) +: 4] == 4'h0)
                        && !r_disp_dp[N_DIG-1-i];
    end
  end

  always_comb begin
    w_nib     = r_disp_data[4*r_idx +: 4];
    w_drive   = (r_phase != 4'h0) && (r_phase <= r_bright);
    w_dig_nxt = '1;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = DP_OFF;
    if (w_drive) begin
      w_dig_nxt[r_idx] = 1'b0;
      if (!(lz_en && w_supp[r_idx])) w_seg_nxt = seg_pol(hex_glyph(w_nib), SEG_ACT_LOW);
      w_dp_nxt = r_disp_dp[r_idx] ^ SEG_ACT_LOW;
    end
  end

  always_ff @(posedge ck) begin
    if (R) begin
      r_phase     <= '0;
      r_idx       <= '0;
      r_bright    <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend      <= 1'b0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_frame     <= 1'b0;
      r_dig       <= '1;
      r_seg       <= SEG_OFF;
      r_dp        <= DP_OFF;
    end else begin
      r_frame <= 1'b0;
      if (w_tick) begin
        r_phase <= r_phase + 4'd1;
        // Level is taken as phase 0 (always blank) ends, before any driven phase.
        if (r_phase == 4'h0) r_bright <= bright;
        if (w_slot_end) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_wrap && r_pend) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
        r_frame     <= 1'b1;
      end
      // A load coinciding with the commit refills pending after the old copy moves out.
      if (load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp_in;
        r_pend      <= 1'b1;
      end else if (w_wrap) begin
        r_pend      <= 1'b0;
      end
      r_dig <= w_dig_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign Dig   = r_dig;
  assign L     = r_seg;
  assign H     = r_dp;
  assign frame = r_frame;

endmodule

// File: tb/tb_mux_display_ndigit.sv
// Self-checking bench for mux_display_ndigit (4 digits, one sub-tick per clock).
module tb_mux_display_ndigit;

  logic        ck = 1'b0;
  logic        R;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  bright;
  logic        lz_en;
  logic [3:0]  Dig;
  logic [6:0]  L;
  logic        H;
  logic        frame;

  always #5 ck = ~ck;

  mux_display_ndigit #(
    .N_DIG(4), .CLK_HZ(1600), .SCAN_HZ(100), .SEG_ACT_LOW(1'b1)
  ) dut (
    .ck(ck), .R(R), .load(load), .data(data), .dp_in(dp_in), .bright(bright),
    .lz_en(lz_en), .Dig(Dig), .L(L), .H(H), .frame(frame)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Glyphs built from the segment letters each hex character lights.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] g;
    g = '0;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";  4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg"; 4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg"; 4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";  default: s = "aefg";
    endcase
    for (int i = 0; i < s.len(); i++) g[6 - (s[i] - "a")] = 1'b1;
    return g;
  endfunction

  // Reference model: k counts clock edges since reset release; slot/phase follow arithmetically.
  int unsigned k;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic        m_pf;
  int unsigned m_b;
  logic [3:0]  e_dig;
  logic [6:0]  e_L;
  logic        e_H, e_frame;

  always @(posedge ck) begin
    if (R) begin
      k = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_pf = 1'b0; m_b = 0;
      e_dig = 4'hF; e_L = 7'h7F; e_H = 1'b1; e_frame = 1'b0;
    end else begin
      int unsigned ph, idx, top;
      logic drv, sup;
      logic [3:0] nib;
      ph  = k % 16;
      idx = (k / 16) % 4;
      nib = m_disp[4*idx +: 4];
      top = 0;
      for (int i = 0; i < 4; i++) if (m_disp[4*i +: 4] != 0 || m_ddp[i]) top = i;
      sup = lz_en && (idx > top);
      drv = (ph >= 1) && (ph <= m_b);
      e_dig   = drv ? ~(4'b0001 << idx) : 4'hF;
      e_L     = (drv && !sup) ? ~glyph(nib) : 7'h7F;
      e_H     = drv ? ~m_ddp[idx] : 1'b1;
      e_frame = 1'b0;
      if (ph == 0) m_b = bright;
      if (k % 64 == 63 && m_pf) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pf = 1'b0; e_frame = 1'b1;
      end
      if (load) begin m_pend = data; m_pdp = dp_in; m_pf = 1'b1; end
      k++;
    end
  end

  logic [6:0] seen_L [4];
  logic       seen_H [4];
  int         frames;
  int         lows;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge ck);
    chk("Dig", 32'(Dig), 32'(e_dig));
    chk("L", 32'(L), 32'(e_L));
    chk("H", 32'(H), 32'(e_H));
    chk("frame", 32'(frame), 32'(e_frame));
    if (frame) frames++;
    if (Dig != 4'hF) lows++;
    for (int i = 0; i < 4; i++) if (Dig == ~(4'b0001 << i)) begin
      seen_L[i] = L; seen_H[i] = H;
    end
  endtask

  initial begin
    R = 1'b1; load = 1'b0; data = '0; dp_in = '0; bright = 4'd15; lz_en = 1'b0;
    frames = 0; lows = 0;
    repeat (3) step();
    chk("rst_Dig", 32'(Dig), 32'hF);
    chk("rst_L", 32'(L), 32'h7F);
    chk("rst_H", 32'(H), 32'h1);
    chk("rst_frame", 32'(frame), 32'h0);
    R = 1'b0;

    // Slot timing: blank on phase 0, then digit 0..3 one-cold for 15 cycles each.
    for (int s = 1; s <= 64; s++) begin
      step();
      if ((s - 1) % 16 == 0) chk("scan_blank", 32'(Dig), 32'hF);
      else chk("scan_dig", 32'(Dig), 32'(~(4'b0001 << ((s - 1) / 16)) & 4'hF));
    end

    // Load mid-frame, commit at the wrap.
    while (k % 64 != 20) step();
    load = 1'b1; data = 16'h12A0; dp_in = 4'b0000;
    step();
    load = 1'b0; frames = 0;
    while (k % 64 != 63) step();
    chk("pre_commit_frames", 32'(frames), 32'd0);
    chk("pre_commit_d1", 32'(seen_L[1]), 32'(~glyph(4'h0) & 7'h7F));
    repeat (65) step();
    chk("commit_frames", 32'(frames), 32'd1);
    chk("commit_d0", 32'(seen_L[0]), 32'(~glyph(4'h0) & 7'h7F));
    chk("commit_d1", 32'(seen_L[1]), 32'(~glyph(4'hA) & 7'h7F));
    chk("commit_d2", 32'(seen_L[2]), 32'(~glyph(4'h2) & 7'h7F));
    chk("commit_d3", 32'(seen_L[3]), 32'(~glyph(4'h1) & 7'h7F));

    // Load landing in the commit cycle itself.
    while (k % 64 != 20) step();
    load = 1'b1; data = 16'h1111;
    step();
    load = 1'b0;
    while (k % 64 != 63) step();
    load = 1'b1; data = 16'h2222; frames = 0;
    step();
    load = 1'b0;
    chk("simul_frame", 32'(frame), 32'h1);
    repeat (63) step();
    chk("simul_frames1", 32'(frames), 32'd1);
    for (int i = 0; i < 4; i++) chk("simul_1111", 32'(seen_L[i]), 32'(~glyph(4'h1) & 7'h7F));
    step();
    chk("simul_frames2", 32'(frames), 32'd2);
    repeat (64) step();
    chk("simul_2222", 32'(seen_L[0]), 32'(~glyph(4'h2) & 7'h7F));

    // Brightness: low cycles per full slot equal the level.
    foreach (seen_H[b]) begin
      int unsigned lvl;
      lvl = (b == 0) ? 0 : (b == 1) ? 4 : (b == 2) ? 15 : 9;
      bright = 4'(lvl);
      repeat (20) step();
      while (k % 16 != 0) step();
      lows = 0;
      repeat (16) step();
      chk("bright_lows", 32'(lows), 32'(lvl));
    end
    bright = 4'd15;

    // Leading-zero suppression, then a decimal point halting it.
    lz_en = 1'b1;
    load = 1'b1; data = 16'h0070; dp_in = 4'b0000;
    step();
    load = 1'b0;
    repeat (128) step();
    chk("lz_d3", 32'(seen_L[3]), 32'h7F);
    chk("lz_d2", 32'(seen_L[2]), 32'h7F);
    chk("lz_d1", 32'(seen_L[1]), 32'(~glyph(4'h7) & 7'h7F));
    chk("lz_d0", 32'(seen_L[0]), 32'(~glyph(4'h0) & 7'h7F));
    load = 1'b1; dp_in = 4'b0100;
    step();
    load = 1'b0;
    repeat (128) step();
    chk("lzdp_d3", 32'(seen_L[3]), 32'h7F);
    chk("lzdp_d2", 32'(seen_L[2]), 32'(~glyph(4'h0) & 7'h7F));
    chk("lzdp_h2", 32'(seen_H[2]), 32'h0);
    lz_en = 1'b0;

    // Reset in slot 2 with a pending load: buffer lost, no frame pulse.
    while (k % 64 != 36) step();
    load = 1'b1; data = 16'h5555; dp_in = 4'b1111;
    step();
    load = 1'b0; R = 1'b1;
    repeat (2) step();
    R = 1'b0; frames = 0;
    repeat (130) step();
    chk("rstmid_frames", 32'(frames), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_L", 32'(seen_L[i]), 32'(~glyph(4'h0) & 7'h7F));
      chk("rstmid_H", 32'(seen_H[i]), 32'h1);
    end

    // Random traffic against the model.
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) begin
        load  = 1'b1;
        data  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      step();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_display_ndigit.md
Name: mux_display_ndigit

Overview:
- Parametrised N-digit multiplexed 7-segment display driver, successor to the fixed 4-digit scanner.
- Adds a double-buffered load (tear-free frame update), per-digit decimal points, 16-level brightness PWM with an anti-ghost blank phase, and optional leading-zero suppression.
- Sits between the application datapath and the board's common-anode digit/segment pins.

Parameters:
- N_DIG, 4, number of digits (2..8); digit 0 is least significant and rightmost.
- CLK_HZ, 50000000, ck frequency in Hz.
- SCAN_HZ, 1000, digit slot rate in Hz; one slot per digit.
- SEG_ACT_LOW, 1, 1 means L/H are active-low; 0 means active-high.

Ports:
- ck  in  1  system clock.
- R  in  1  synchronous reset, active-high.
- load  in  1  single-cycle strobe that captures data/dp_in into the pending buffer.
- data  in  4*N_DIG  hex nibbles; nibble i = data[4i+3:4i] drives digit i.
- dp_in  in  N_DIG  decimal point per digit.
- bright  in  4  brightness level 0..15; sampled at every slot start.
- lz_en  in  1  leading-zero suppression enable.
- Dig  out  N_DIG  digit enables, active-low, one-cold.
- L  out  7  segments a..g, polarity per SEG_ACT_LOW.
- H  out  1  decimal point, polarity per SEG_ACT_LOW.
- frame  out  1  one-cycle pulse when the pending buffer is committed to the display buffer.

Behaviour:
- Reset (R=1 at a ck edge): index=0, sub-phase=0, prescaler=0, pending and display buffers=0, pend flag=0, frame=0, Dig all 1, L/H inactive. R overrides every other input, including during a slot.
- Prescaler: SUB_DIV = CLK_HZ/(SCAN_HZ*16), integer division, minimum 1. A sub-tick fires every SUB_DIV cycles.
- Slot structure: each slot is 16 sub-ticks, sub-phase 0..15. The slot ends when phase 15 completes.
- Digit index: increments 0..N_DIG-1 at each slot end and wraps from N_DIG-1 to 0.
- Brightness: bright is latched at slot start.
  - Digit is driven during sub-phases 1..b, where b is the latched level.
  - Sub-phase 0 is always blanked (anti-ghost).
  - b=0 gives a dark display; b=15 gives 15/16 duty.
- Pending buffer: load=1 writes data/dp_in to the pending buffer and sets pend. Repeated loads overwrite; the last one wins.
- Commit: at the slot end that wraps index N_DIG-1 to 0, if pend=1:
  - display buffer <= pending buffer; pend cleared; frame=1 for one cycle.
  - If load=1 in that same cycle, the commit uses the old pending contents. The new value is then written to pending and pend remains 1.
  - No commit happens mid-frame.
- Leading-zero suppression (lz_en=1): scanning from digit N_DIG-1 downward, a digit is blanked (L inactive) while its nibble is 0 and all higher digits were blanked.
  - Suppression stops at the first nonzero nibble or the first set dp.
  - Digit 0 is never suppressed.
  - Computed on the display buffer only.
- Decode: nibbles 0..F map to hex glyphs 0-9, A, b, C, d, E, F.
- Output timing: Dig, L and H are registered and change 1 cycle after the internal index/phase update. Registered outputs guarantee no glitches on pins.

Decomposition:
- Shared package holds:
  - the 16-entry segment glyph constants (abcdefg order);
  - the BLANK_SEG constant;
  - the PHASES=16 constant;
  - a function computing SUB_DIV.
- Natural sub-module: tick_gen (parametrised prescaler with a synchronous active-high R, emitting a one-cycle tick every DIV cycles). It is reused for the sub-tick.
- Glyph decode is a combinational function from the package, not a separate module.

Test Plan:
- Reset and slot timing (CLK_HZ=1600, SCAN_HZ=100, so SUB_DIV=1 and a slot is 16 cycles): assert R for 3 cycles, release -> Dig=1111 and L inactive at release. Digit 0 enables from cycle 2 of its slot, and the Dig pattern cycles 1110, 1101, 1011, 0111 every 16 cycles.
- Load and commit: load data=16'h12A0 mid-frame -> display unchanged until the wrap. Then frame pulses once and the slots show 0, A, 2, 1 on digits 0..3.
- Simultaneous load at the commit cycle: load 16'h1111 committed and 16'h2222 loaded in the same cycle -> 1111 displayed that frame, 2222 committed at the next wrap with a second frame pulse.
- Brightness: bright=0 -> Dig never goes low. bright=4 -> Dig low for exactly 4 of 16 cycles per slot, on sub-phases 1..4. bright=15 -> low for 15/16.
- Leading zeros: lz_en=1 with data=16'h0070 -> digits 3 and 2 blanked, digit 1 shows 7, digit 0 shows 0. With dp_in=4'b0100 (dp on digit 2), digit 2 shows 0 with the point lit.
- Reset mid-operation: assert R with pend=1 in slot 2 -> the pending buffer is lost, the display shows all 0, and no frame pulse occurs.
